hqm_lsp_atm_mem_2par_resp_scrub: RTL and testbench
==================================================

Name: hqm_lsp_atm_mem_2par_resp_scrub

Overview:
- Memory-side responder for the LSP ATM RMW pipe's 2-port (1R/1W) RAM interface.
- Stores WIDTH+1-bit words that carry two interleaved odd-parity bits.
- Serves pipe reads with 1-cycle latency and checks both parities on every returned word.
- A background scrubber walks all entries during idle read-port cycles, re-checks parity, and logs errors for the LSP error/status path.

Parameters:
- DEPTH, 8, number of entries.
- WIDTH, 13, logical pipe word width; stored width is WIDTH+1 (bits 13:12 parity, 11:0 data).
- DEPTHB2, AW_logb2(DEPTH-1)+1, address width.
- SCRUB_IDLE, 16, consecutive idle read-port cycles before each scrub read.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_write  in  1  write strobe
- mem_write_addr  in  DEPTHB2  write address
- mem_write_data  in  WIDTH+1  write data: [13] odd parity of bits 11,9,7,5,3,1; [12] odd parity of bits 10,8,6,4,2,0
- mem_read  in  1  read strobe
- mem_read_addr  in  DEPTHB2  read address
- mem_read_data  out  WIDTH+1  read data, valid the cycle after mem_read
- scrub_en  in  1  scrubber enable (level)
- err_inj  in  1  one-shot: invert bit 13 of the next write's stored data
- rd_par_err  out  1  registered parity error on functional read data
- scrub_err  out  1  one-cycle pulse, scrub parity error detected
- scrub_err_cnt  out  8  saturating count of scrub errors
- scrub_err_addr  out  DEPTHB2  address of first scrub error since reset
- scrub_done  out  1  one-cycle pulse, scrub pass reached entry DEPTH-1
- busy  out  1  scrubber not in IDLE

Behaviour:
- Reset (async, rst=1):
  - All entries are set to 14'h3000 (data 0, both parities correct).
  - mem_read_data=14'h3000.
  - All other outputs are 0; scrub_err_addr=0.
  - Scrub pointer=0; FSM=IDLE; err_inj latch cleared.
  - Reset asserted mid-scrub aborts the scrub with no error logged.
- Parity rule: a group is correct when XOR of its 6 data bits and its parity bit equals 1. The error flag is the OR of both group errors.
- Write: takes effect at the clk edge where mem_write=1.
  - If err_inj was seen on a prior cycle or the same cycle, stored bit 13 is inverted and the latch clears.
  - Repeated err_inj before a write still corrupts only that one write.
- Read: at edge N with mem_read=1, mem_read_data is updated; it holds until the next functional read.
  - Same-cycle read and write to the same address returns the OLD data (read-before-write).
  - rd_par_err is set for one cycle at N+1 when the returned word fails parity; otherwise 0.
- Scrub FSM states: IDLE, WAIT, READ, CHECK.
  - IDLE -> WAIT when scrub_en=1; idle counter is cleared.
  - WAIT: the counter increments on each cycle with mem_read=0 and resets to 0 when mem_read=1. At count SCRUB_IDLE-1 with mem_read=0, go to READ.
  - READ: internal read of the pointer entry, captured in a separate scrub register. If mem_read=1 this cycle, the scrub read is deferred (stays in READ); a functional read always has priority.
  - CHECK: when the captured word fails parity:
    - scrub_err pulses;
    - scrub_err_cnt increments, saturating at 255;
    - scrub_err_addr is loaded only if scrub_err_cnt was 0.
  - CHECK then updates the pointer:
    - pointer = DEPTH-1: pointer wraps to 0 and scrub_done pulses.
    - otherwise: pointer increments.
  - CHECK -> WAIT.
  - scrub_en=0 in any state -> IDLE at the next edge; the pointer is kept and the partial pass resumes later.
  - A write to the scrubbed address between READ and CHECK does not alter the check, which uses captured data.
- The scrubber never writes the array and never disturbs mem_read_data.

Test Plan:
1. Reset, then read addr 5 -> mem_read_data=14'h3000 the next cycle, rd_par_err=0.
2. Write addr 3 data 14'h0FFF (12 ones, both groups need p=1, so 14'h3FFF is correct; 14'h0FFF is wrong). Read addr 3 -> 14'h0FFF, rd_par_err=1 one cycle. Rewrite 14'h3FFF and read -> rd_par_err=0.
3. err_inj=1, then write addr 2 with 14'h3000 -> read returns 14'h1000, rd_par_err=1. Write addr 2 again with 14'h3000 -> read returns 14'h3000, no error.
4. Same-cycle read and write to addr 6 (old 14'h3000, new 14'h3001 with bit0 set so parity 12 flips: 14'h2001) -> read returns 14'h3000; a following read returns 14'h2001.
5. With scrub_en=1, no traffic, and entries 1 and 4 corrupted:
   - First scrub_err pulse points at addr 1; scrub_err_addr=1.
   - scrub_err_cnt=2 after one pass; scrub_done pulses once per 8 entries.
   - Each entry is checked after 16 idle cycles.
6. mem_read toggled every 10 cycles during WAIT -> no scrub READ ever occurs and busy=1. Set scrub_en=0 -> busy=0 the next cycle and the pointer is retained. Assert rst mid-READ -> all outputs clear.

Source files
------------

// File: rtl/hqm_lsp_atm_mem_2par_resp_scrub.sv
// 1R/1W responder RAM for the LSP ATM RMW pipe: two interleaved odd-parity bits per word,
// checked on every functional read, plus an idle-cycle background scrubber with error logging.
module hqm_lsp_atm_mem_2par_resp_scrub #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 13,
  parameter int DEPTHB2    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int SCRUB_IDLE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_write,
  input  logic [DEPTHB2-1:0] mem_write_addr,
  input  logic [WIDTH:0]     mem_write_data,
  input  logic               mem_read,
  input  logic [DEPTHB2-1:0] mem_read_addr,
  output logic [WIDTH:0]     mem_read_data,
  input  logic               scrub_en,
  input  logic               err_inj,
  output logic               rd_par_err,
  output logic               scrub_err,
  output logic [7:0]         scrub_err_cnt,
  output logic [DEPTHB2-1:0] scrub_err_addr,
  output logic               scrub_done,
  output logic               busy
);

  localparam int DW = WIDTH + 1;
  localparam int CW = $clog2(SCRUB_IDLE + 1);
  localparam logic [DW-1:0] RST_WORD = {2'b11, {(DW-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_CHECK} state_t;

  // Top bit covers odd data bits, next bit covers even data bits; each group must XOR to 1.
  function automatic logic par_err(input logic [DW-1:0] w);
    logic po, pe;
    po = w[DW-1];
    pe = w[DW-2];
    for (int i = 0; i < DW-2; i++) begin
      if (i[0]) po ^= w[i];
      else      pe ^= w[i];
    end
    return !(po && pe);
  endfunction

  logic [DW-1:0]      mem [DEPTH];
  logic               inj_pend;
  logic               inj;
  state_t             state, nxt;
  logic [CW-1:0]      idle_cnt;
  logic [DEPTHB2-1:0] ptr;
  logic [DW-1:0]      scrub_word;
  logic               cnt_clr, cnt_inc, scrub_cap, do_check;

  assign inj  = inj_pend | err_inj;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
      inj_pend <= 1'b0;
    end else begin
      if (mem_write) begin
        mem[mem_write_addr] <= mem_write_data ^ {inj, {(DW-1){1'b0}}};
        inj_pend            <= 1'b0;
      end else if (err_inj) begin
        inj_pend <= 1'b1;
      end
    end
  end

  // Read-before-write falls out of the nonblocking array update above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_data <= RST_WORD;
      rd_par_err    <= 1'b0;
    end else begin
      rd_par_err <= 1'b0;
      if (mem_read) begin
        mem_read_data <= mem[mem_read_addr];
        rd_par_err    <= par_err(mem[mem_read_addr]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    scrub_cap = 1'b0;
    do_check  = 1'b0;
    case (state)
      S_IDLE: if (scrub_en) begin
        nxt     = S_WAIT;
        cnt_clr = 1'b1;
      end
      S_WAIT: begin
        if (mem_read)                              cnt_clr = 1'b1;
        else if (idle_cnt == CW'(SCRUB_IDLE - 1))  nxt     = S_READ;
        else                                       cnt_inc = 1'b1;
      end
      // Functional reads own the read port; the scrub read just waits.
      S_READ: if (!mem_read) begin
        scrub_cap = 1'b1;
        nxt       = S_CHECK;
      end
      S_CHECK: begin
        do_check = 1'b1;
        cnt_clr  = 1'b1;
        nxt      = S_WAIT;
      end
      default: nxt = S_IDLE;
    endcase
    if (!scrub_en) begin
      nxt       = S_IDLE;
      cnt_inc   = 1'b0;
      scrub_cap = 1'b0;
      do_check  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt       <= '0;
      ptr            <= '0;
      scrub_word     <= RST_WORD;
      scrub_err      <= 1'b0;
      scrub_err_cnt  <= '0;
      scrub_err_addr <= '0;
      scrub_done     <= 1'b0;
    end else begin
      scrub_err  <= 1'b0;
      scrub_done <= 1'b0;
      if (cnt_clr)      idle_cnt <= '0;
      else if (cnt_inc) idle_cnt <= idle_cnt + 1'b1;
      if (scrub_cap) scrub_word <= mem[ptr];
      if (do_check) begin
        if (par_err(scrub_word)) begin
          scrub_err <= 1'b1;
          if (scrub_err_cnt != 8'hFF) scrub_err_cnt  <= scrub_err_cnt + 1'b1;
          if (scrub_err_cnt == 8'h00) scrub_err_addr <= ptr;
        end
        if (ptr == DEPTHB2'(DEPTH - 1)) begin
          ptr        <= '0;
          scrub_done <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hqm_lsp_atm_mem_2par_resp_scrub.sv
// Bench for the parity-checked responder RAM: vector table for functional traffic,
// read scoreboard, and cycle-exact sequences for the scrubber.
module tb_hqm_lsp_atm_mem_2par_resp_scrub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_write_addr = '0;
  logic [13:0] mem_write_data = '0;
  logic        mem_read = 1'b0;
  logic [2:0]  mem_read_addr = '0;
  logic [13:0] mem_read_data;
  logic        scrub_en = 1'b0;
  logic        err_inj = 1'b0;
  logic        rd_par_err;
  logic        scrub_err;
  logic [7:0]  scrub_err_cnt;
  logic [2:0]  scrub_err_addr;
  logic        scrub_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [13:0] wdata;
    logic        inj;
    logic        re;
    logic [2:0]  raddr;
    logic [13:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [13:0] data;
    logic        err;
  } rd_exp_t;

  vec_t    vecs[$];
  rd_exp_t sb[$];
  logic    rd_seen = 1'b0;

  hqm_lsp_atm_mem_2par_resp_scrub dut (
    .clk(clk), .rst(rst),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .scrub_en(scrub_en), .err_inj(err_inj), .rd_par_err(rd_par_err),
    .scrub_err(scrub_err), .scrub_err_cnt(scrub_err_cnt), .scrub_err_addr(scrub_err_addr),
    .scrub_done(scrub_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: a read sampled at a posedge is compared at the following negedge.
  always @(posedge clk) rd_seen <= mem_read && !rst;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_seen) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          rd_exp_t e;
          e = sb.pop_front();
          chk("rd_data", 32'(mem_read_data), 32'(e.data));
          chk("rd_par_err", 32'(rd_par_err), 32'(e.err));
        end
      end else begin
        chk("rd_par_err_idle", 32'(rd_par_err), 0);
      end
    end
  end

  task automatic drive_idle();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    err_inj   = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [13:0] d, input logic e);
    rd_exp_t x;
    mem_read      = 1'b1;
    mem_read_addr = a;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [13:0] d);
    mem_write      = 1'b1;
    mem_write_addr = a;
    mem_write_data = d;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_reset();
    drive_idle();
    scrub_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // we waddr wdata inj re raddr exp_data exp_err
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd5, 14'h3000, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 14'h0FFF, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd3, 14'h0FFF, 1'b1});
    vecs.push_back('{1'b1, 3'd3, 14'h3FFF, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd3, 14'h3FFF, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b1, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 14'h3000, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd2, 14'h1000, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 14'h3000, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd2, 14'h3000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b1, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b1, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 14'h3000, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd2, 14'h1000, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 14'h3000, 1'b0, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd2, 14'h3000, 1'b0});
    vecs.push_back('{1'b1, 3'd7, 14'h3000, 1'b1, 1'b0, 3'd0, 14'h0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd7, 14'h1000, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 14'h2001, 1'b0, 1'b1, 3'd6, 14'h3000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 14'h0000, 1'b0, 1'b1, 3'd6, 14'h2001, 1'b0});

    do_reset();
    chk("rst_rd_data", 32'(mem_read_data), 32'h3000);
    chk("rst_rd_par_err", 32'(rd_par_err), 0);
    chk("rst_scrub_err", 32'(scrub_err), 0);
    chk("rst_err_cnt", 32'(scrub_err_cnt), 0);
    chk("rst_err_addr", 32'(scrub_err_addr), 0);
    chk("rst_done", 32'(scrub_done), 0);
    chk("rst_busy", 32'(busy), 0);

    foreach (vecs[i]) begin
      mem_write      = vecs[i].we;
      mem_write_addr = vecs[i].waddr;
      mem_write_data = vecs[i].wdata;
      err_inj        = vecs[i].inj;
      mem_read       = 1'b0;
      if (vecs[i].re) do_read(vecs[i].raddr, vecs[i].exp_data, vecs[i].exp_err);
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);

    // Full scrub pass over a clean array with entries 1 and 4 corrupted.
    do_reset();
    do_write(3'd1, 14'h1000);
    do_write(3'd4, 14'h0000);
    scrub_en = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk);
      chk("pass_scrub_err", 32'(scrub_err), 32'(i == 37 || i == 91));
      chk("pass_scrub_done", 32'(scrub_done), 32'(i == 145));
      if (i == 38) chk("pass_err_addr", 32'(scrub_err_addr), 1);
    end
    chk("pass_err_cnt", 32'(scrub_err_cnt), 2);
    chk("pass_busy", 32'(busy), 1);
    repeat (130 * 144) @(negedge clk);
    chk("sat_err_cnt", 32'(scrub_err_cnt), 255);
    chk("sat_err_addr", 32'(scrub_err_addr), 1);

    // Functional reads while in READ defer the scrub read by the same number of cycles.
    do_reset();
    do_write(3'd0, 14'h0000);
    for (int i = 0; i < 30; i++) begin
      scrub_en = 1'b1;
      mem_read = 1'b0;
      if (i >= 17 && i <= 19) do_read(3'd5, 14'h3000, 1'b0);
      @(negedge clk);
      chk("defer_scrub_err", 32'(scrub_err), 32'(i + 1 == 22));
    end
    drive_idle();

    // Periodic reads keep the scrubber parked in WAIT; corrupt entry 0 would expose a READ.
    do_reset();
    do_write(3'd0, 14'h0000);
    scrub_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mem_read = 1'b0;
      if (i % 10 == 9) do_read(3'd0, 14'h0000, 1'b1);
      @(negedge clk);
      chk("park_scrub_err", 32'(scrub_err), 0);
      chk("park_busy", 32'(busy), 1);
    end
    drive_idle();
    scrub_en = 1'b0;
    @(negedge clk);
    chk("park_off_busy", 32'(busy), 0);
    chk("park_err_cnt", 32'(scrub_err_cnt), 0);

    // Pointer retained across a disable; reset mid-READ clears everything.
    do_reset();
    do_write(3'd2, 14'h0000);
    scrub_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("ret_scrub_err", 32'(scrub_err), 0);
    end
    scrub_en = 1'b0;
    @(negedge clk);
    chk("ret_off_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    scrub_en = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      chk("ret_resume_err", 32'(scrub_err), 32'(i == 19));
      if (i == 20) begin
        chk("ret_err_addr", 32'(scrub_err_addr), 2);
        chk("ret_err_cnt", 32'(scrub_err_cnt), 1);
      end
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err_cnt", 32'(scrub_err_cnt), 0);
    chk("midrst_err_addr", 32'(scrub_err_addr), 0);
    chk("midrst_scrub_err", 32'(scrub_err), 0);
    chk("midrst_done", 32'(scrub_done), 0);
    chk("midrst_rd_data", 32'(mem_read_data), 32'h3000);
    chk("midrst_rd_err", 32'(rd_par_err), 0);
    scrub_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_err_cnt", 32'(scrub_err_cnt), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
